// File: rtl/switch_debouncer.sv
// Purpose: synchronise, debounce and edge-detect a vector of raw toggle switches.
// Latency: 2 sync cycles + (STABLE_SAMPLES-1..STABLE_SAMPLES) ticks + 1 register cycle.
// Backpressure: none; free-running conditioning stage, outputs are level/pulse only.
module switch_debouncer #(
  parameter int NUM_SW         = 18,
  parameter int TICK_DIV       = 50000,
  parameter int STABLE_SAMPLES = 16,
  parameter int IDX_W          = $clog2(NUM_SW)
) (
  input  logic              CLOCK_50_I,
  input  logic              resetn,
  input  logic [NUM_SW-1:0] SWITCH_I,
  output logic [NUM_SW-1:0] SWITCH_DEB_O,
  output logic [NUM_SW-1:0] SWITCH_RISE_O,
  output logic [NUM_SW-1:0] SWITCH_FALL_O,
  output logic              CHANGE_O,
  output logic [IDX_W-1:0]  LAST_IDX_O,
  output logic              SAMPLE_TICK_O
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_SAMPLES);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]    CNT_MAX   = CW'(STABLE_SAMPLES - 1);
  localparam logic [IDX_W-1:0] IDX_NONE  = '1;

  logic [NUM_SW-1:0]         sync1_q, sync1_d;
  logic [NUM_SW-1:0]         sync2_q, sync2_d;
  logic [PW-1:0]             presc_q, presc_d;
  logic [NUM_SW-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUM_SW-1:0]         deb_q, deb_d;
  logic [NUM_SW-1:0]         rise_q, rise_d;
  logic [NUM_SW-1:0]         fall_q, fall_d;
  logic                      change_q, change_d;
  logic [IDX_W-1:0]          last_idx_q, last_idx_d;
  logic                      tick;

  // Two-flop synchroniser; only the second stage feeds the debouncer.
  always_comb begin
    sync1_d = SWITCH_I;
    sync2_d = sync1_q;
  end

  // Prescaler: the tick is the terminal count, so it lands TICK_DIV cycles after reset.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Per-bit debounce: a change commits only after STABLE_SAMPLES differing ticks in a row.
  always_comb begin
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    rise_d = '0;
    fall_d = '0;
    if (tick) begin
      for (int i = 0; i < NUM_SW; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i]  = '0;
          deb_d[i]  = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Event summary: any-change flag and highest changed index (held when nothing changes).
  always_comb begin
    change_d   = |(rise_d | fall_d);
    last_idx_d = last_idx_q;
    for (int i = 0; i < NUM_SW; i++) begin
      if (rise_d[i] | fall_d[i]) begin
        last_idx_d = IDX_W'(i);
      end
    end
  end

  // State registers; reset wins over everything and discards partial debounce progress.
  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
      deb_q      <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      change_q   <= 1'b0;
      last_idx_q <= IDX_NONE;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      change_q   <= change_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign SWITCH_DEB_O  = deb_q;
  assign SWITCH_RISE_O = rise_q;
  assign SWITCH_FALL_O = fall_q;
  assign CHANGE_O      = change_q;
  assign LAST_IDX_O    = last_idx_q;
  assign SAMPLE_TICK_O = tick;

endmodule
